// File: rtl/fsk_demod_rx.sv
// fsk_demod_rx: FSK bit-window demodulator with preamble hunt and word framing.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   fsk_in            - asynchronous FSK square wave
//   data_out/valid    - last complete payload word (MSB first) and its update pulse
//   bit_out/valid     - last decided bit and its per-window pulse
//   locked            - high while the receiver is framing payload words
//   carrier_lost      - pulse on a window that saw no rising edges
//   period_meas       - clk cycles between the last two rising edges of fsk_in
module fsk_demod_rx #(
  parameter int DATA_W       = 12,
  parameter int CNT_W        = 16,
  parameter int BIT_CYCLES   = 2000,
  parameter int EDGE_THRESH  = 15,
  parameter int PREAMBLE_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsk_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              locked,
  output logic              carrier_lost,
  output logic [CNT_W-1:0]  period_meas
);

  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int ZW    = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WRAP_VAL = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(EDGE_THRESH);
  localparam logic [ZW-1:0]    PRE_MIN  = ZW'(PREAMBLE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

  state_t             state, state_next;
  logic               sync1, sync2, sync3, edge_p;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [ZW-1:0]      zero_cnt;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  shreg;
  logic               wrap, bit_dec, lost, word_done;
  logic [DATA_W-1:0]  shifted;

  // Two-flop synchroniser plus a delay stage; the edge pulse is registered,
  // giving three cycles from pin to edge_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync1  <= fsk_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_p <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt     <= '0;
      period_meas <= '0;
    end else if (edge_p) begin
      period_meas <= per_cnt;
      per_cnt     <= CNT_W'(1);
    end else if (per_cnt != CNT_MAX) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (edge_p) state_next = HUNT;
      HUNT: if (wrap) begin
              if (lost)                             state_next = IDLE;
              else if (bit_dec && zero_cnt >= PRE_MIN) state_next = DATA;
            end
      DATA: if (wrap && lost) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window decision and framing terms
  always_comb begin
    wrap      = (state != IDLE) && (win_cnt == WRAP_VAL);
    bit_dec   = (edge_cnt >= THRESH);
    lost      = (edge_cnt == '0);
    shifted   = {shreg[DATA_W-2:0], bit_dec};
    word_done = wrap && (state == DATA) && !lost && (idx == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      zero_cnt     <= '0;
      idx          <= '0;
      shreg        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      carrier_lost <= 1'b0;
      locked       <= 1'b0;
    end else begin
      bit_valid    <= wrap;
      carrier_lost <= wrap && lost;
      data_valid   <= word_done;
      locked       <= (state_next == DATA);
      if (wrap) bit_out <= bit_dec;

      // IDLE holds the timer at 0; the waking edge counts toward the first window.
      // An edge coincident with wrap belongs to the new window.
      if (state == IDLE || wrap) begin
        win_cnt  <= '0;
        edge_cnt <= CNT_W'(edge_p);
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (edge_p && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + 1'b1;
      end

      if (state != HUNT) begin
        zero_cnt <= '0;
      end else if (wrap) begin
        if (lost || bit_dec)          zero_cnt <= '0;
        else if (zero_cnt != PRE_MIN) zero_cnt <= zero_cnt + 1'b1;
      end

      if (state != DATA) begin
        idx   <= '0;
        shreg <= '0;
      end else if (wrap) begin
        if (lost) begin
          idx   <= '0;
          shreg <= '0;
        end else begin
          shreg <= shifted;
          idx   <= word_done ? '0 : idx + 1'b1;
          if (word_done) data_out <= shifted;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_demod_rx.sv
// tb_fsk_demod_rx: scoreboard bench for fsk_demod_rx with 100-cycle bit windows.
module tb_fsk_demod_rx;
  localparam int DATA_W       = 12;
  localparam int CNT_W        = 16;
  localparam int BIT_CYCLES   = 100;
  localparam int EDGE_THRESH  = 8;
  localparam int PREAMBLE_LEN = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fsk_in = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              bit_out;
  logic              bit_valid;
  logic              locked;
  logic              carrier_lost;
  logic [CNT_W-1:0]  period_meas;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fsk_demod_rx #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BIT_CYCLES(BIT_CYCLES),
    .EDGE_THRESH(EDGE_THRESH), .PREAMBLE_LEN(PREAMBLE_LEN)
  ) dut (
    .clk(clk), .rst(rst), .fsk_in(fsk_in),
    .data_out(data_out), .data_valid(data_valid),
    .bit_out(bit_out), .bit_valid(bit_valid),
    .locked(locked), .carrier_lost(carrier_lost),
    .period_meas(period_meas)
  );

  typedef struct {
    logic b;
    logic cl;
    logic lk;
  } exp_bit_t;

  exp_bit_t          bq[$];
  logic [DATA_W-1:0] wq[$];
  int unsigned       dv_times[$];
  exp_bit_t          e;
  logic [DATA_W-1:0] ew;

  // Reference receiver model: 0 idle, 1 hunt, 2 data
  int                m_state = 0;
  int                m_zero  = 0;
  int                m_idx   = 0;
  logic [DATA_W-1:0] m_sh    = '0;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bit_valid) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit_valid got bit=%0b lost=%0b expected no decision", bit_out, carrier_lost);
        end else begin
          e = bq.pop_front();
          if ({bit_out, carrier_lost, locked} !== {e.b, e.cl, e.lk}) begin
            errors++;
            $display("FAIL bit_decision got bit=%0b lost=%0b locked=%0b expected bit=%0b lost=%0b locked=%0b",
                     bit_out, carrier_lost, locked, e.b, e.cl, e.lk);
          end
        end
      end else if (carrier_lost) begin
        checks++;
        errors++;
        $display("FAIL carrier_lost_alone got 1 expected 0 without bit_valid");
      end
      if (data_valid) begin
        checks++;
        dv_times.push_back(cyc);
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data_valid got data=%h expected none", data_out);
        end else begin
          ew = wq.pop_front();
          if (data_out !== ew) begin
            errors++;
            $display("FAIL data_word got %h expected %h", data_out, ew);
          end
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    fsk_in = v;
    repeat (n) @(negedge clk);
  endtask

  // sym: 0 = f0 (5 edges), 1 = f1 (10 edges), 2 = silence
  task automatic send_sym(input int sym);
    int   edges;
    logic b, cl;
    if (m_state == 0 && sym != 2) m_state = 1;
    if (m_state != 0) begin
      edges = (sym == 0) ? 5 : (sym == 1) ? 10 : 0;
      b  = (edges >= EDGE_THRESH);
      cl = (edges == 0);
      if (cl) begin
        m_state = 0; m_zero = 0; m_idx = 0; m_sh = '0;
      end else if (m_state == 1) begin
        if (!b) m_zero++;
        else begin
          if (m_zero >= PREAMBLE_LEN) begin m_state = 2; m_idx = 0; end
          m_zero = 0;
        end
      end else begin
        m_sh = {m_sh[DATA_W-2:0], b};
        if (m_idx == DATA_W - 1) begin wq.push_back(m_sh); m_idx = 0; end
        else m_idx++;
      end
      bq.push_back('{b: b, cl: cl, lk: (m_state == 2)});
    end
    if (sym == 0)      repeat (5)  begin hold(1'b1, 10); hold(1'b0, 10); end
    else if (sym == 1) repeat (10) begin hold(1'b1, 5);  hold(1'b0, 5);  end
    else               hold(1'b0, BIT_CYCLES);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] t;
    t = w;
    for (int i = DATA_W - 1; i >= 0; i--) send_sym(t[i] ? 1 : 0);
  endtask

  task automatic send_sync(input int zeros);
    repeat (zeros) send_sym(0);
    send_sym(1);
  endtask

  task automatic settle(input string name);
    repeat (10) @(negedge clk);
    checks++;
    if (bq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got bits=%0d words=%0d expected 0 0", name, bq.size(), wq.size());
    end
  endtask

  task automatic clear_model();
    bq.delete(); wq.delete(); dv_times.delete();
    m_state = 0; m_zero = 0; m_idx = 0; m_sh = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fsk_in = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({data_out, data_valid, bit_out, bit_valid, locked, carrier_lost, period_meas} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h dv=%0b bit=%0b bv=%0b lk=%0b cl=%0b per=%0d expected all 0",
               data_out, data_valid, bit_out, bit_valid, locked, carrier_lost, period_meas);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_sync_aaa();
    send_sync(6);
    send_word(12'hAAA);
    settle("sync_aaa");
    checks++;
    if (data_out !== 12'hAAA || locked !== 1'b1) begin
      errors++;
      $display("FAIL sync_aaa_final got data=%h locked=%0b expected aaa 1", data_out, locked);
    end
    do_reset();
  endtask

  task automatic test_short_preamble();
    send_sync(4);
    send_sync(1);
    settle("short_preamble");
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL short_preamble_locked got %0b expected 0", locked);
    end
    send_sync(5);
    settle("preamble_five");
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL preamble_five_locked got %0b expected 1", locked);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    send_sync(6);
    send_word(12'hF0F);
    send_word(12'h123);
    settle("back_to_back");
    checks++;
    if (dv_times.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 2", dv_times.size());
    end else if (dv_times[1] - dv_times[0] != 1200) begin
      errors++;
      $display("FAIL b2b_spacing got %0d expected 1200", dv_times[1] - dv_times[0]);
    end
    do_reset();
  endtask

  task automatic test_carrier_lost();
    send_sync(6);
    send_sym(1); send_sym(0); send_sym(1); send_sym(1); send_sym(0);
    send_sym(2);
    settle("carrier_lost");
    checks++;
    if (locked !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL carrier_lost_state got locked=%0b data=%h expected 0 000", locked, data_out);
    end
    do_reset();
  endtask

  task automatic test_period();
    send_sym(1);
    send_sym(1);
    checks++;
    if (period_meas !== 16'd10) begin
      errors++;
      $display("FAIL period_f1 got %0d expected 10", period_meas);
    end
    settle("period");
    do_reset();
    hold(1'b0, 70000);
    hold(1'b1, 6);
    checks++;
    if (period_meas !== 16'hFFFF) begin
      errors++;
      $display("FAIL period_saturate got %0d expected 65535", period_meas);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    send_sync(6);
    send_word(12'hABC);
    send_sym(1); send_sym(1); send_sym(0); send_sym(1); send_sym(1);
    repeat (5) begin hold(1'b1, 5); hold(1'b0, 5); end
    checks++;
    if (locked !== 1'b1 || data_out !== 12'hABC) begin
      errors++;
      $display("FAIL async_pre got locked=%0b data=%h expected 1 abc", locked, data_out);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({data_out, data_valid, bit_out, bit_valid, locked, carrier_lost, period_meas} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got data=%h bit=%0b lk=%0b per=%0d expected all 0",
               data_out, bit_out, locked, period_meas);
    end
    fsk_in = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 20);
    send_sync(6);
    send_word(12'h5A5);
    settle("async_restart");
    checks++;
    if (data_out !== 12'h5A5) begin
      errors++;
      $display("FAIL async_restart_data got %h expected 5a5", data_out);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sync_aaa();
    test_short_preamble();
    test_back_to_back();
    test_carrier_lost();
    test_period();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
